// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Command front end for the 8-bit combinational ALU. Registers
//               ALU inputs, waits a settle time, and returns captured results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [7:0]       cmd_op1,
  input  logic [7:0]       cmd_op2,
  input  logic             cmd_chain,
  output logic [2:0]       alu_opcode,
  output logic [7:0]       alu_operand1,
  output logic [7:0]       alu_operand2,
  input  logic [15:0]      alu_result,
  input  logic             alu_flagC,
  input  logic             alu_flagZ,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int              SC_W          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] C_SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]      C_OP_ADD      = 3'b000;
  localparam logic [2:0]      C_OP_SUB      = 3'b001;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  generate
    if (SETTLE_CYCLES < 1) begin : g_settle_check
      $error("alu_cmd_sequencer: SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [SC_W-1:0]  r_settle_cnt;
  logic [2:0]       r_alu_opcode;
  logic [7:0]       r_alu_op1;
  logic [7:0]       r_alu_op2;
  logic [15:0]      r_rsp_result;
  logic             r_rsp_c;
  logic             r_rsp_z;
  logic [7:0]       r_last_lo;
  logic [CNT_W-1:0] r_op_count;

  logic w_cmd_fire;
  logic w_rsp_fire;
  logic w_capture;
  logic w_carry_valid;

  assign w_cmd_fire    = cmd_valid && (r_state == S_IDLE);
  assign w_rsp_fire    = rsp_ready && (r_state == S_RESP);
  assign w_capture     = (r_state == S_SETTLE) && (r_settle_cnt == '0);
  // Carry is only meaningful for ADD/SUB; other opcodes leave it stale.
  assign w_carry_valid = (r_alu_opcode == C_OP_ADD) || (r_alu_opcode == C_OP_SUB);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_cmd_fire) w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_capture)  w_state_nxt = S_RESP;
      S_RESP:   if (w_rsp_fire) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_alu_opcode <= 3'd0;
      r_alu_op1    <= 8'd0;
      r_alu_op2    <= 8'd0;
      r_rsp_result <= 16'd0;
      r_rsp_c      <= 1'b0;
      r_rsp_z      <= 1'b0;
      r_last_lo    <= 8'd0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_cmd_fire) begin
        r_alu_opcode <= cmd_opcode;
        r_alu_op1    <= cmd_chain ? r_last_lo : cmd_op1;
        r_alu_op2    <= cmd_op2;
        r_settle_cnt <= C_SETTLE_LOAD;
      end else if ((r_state == S_SETTLE) && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - SC_W'(1);
      end

      if (w_capture) begin
        r_rsp_result <= alu_result;
        r_rsp_c      <= w_carry_valid ? alu_flagC : 1'b0;
        r_rsp_z      <= alu_flagZ;
        r_last_lo    <= alu_result[7:0];
      end

      if (w_rsp_fire) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign busy         = (r_state != S_IDLE);
  assign alu_opcode   = r_alu_opcode;
  assign alu_operand1 = r_alu_op1;
  assign alu_operand2 = r_alu_op2;
  assign rsp_result   = r_rsp_result;
  assign rsp_c        = r_rsp_c;
  assign rsp_z        = r_rsp_z;
  assign op_count     = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Directed scoreboard bench; two sequencers with different
//               settle/counter widths, each driving a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, b_rst_n;
  logic       sel;
  logic       cmd_valid;
  logic [2:0] cmd_opcode;
  logic [7:0] cmd_op1, cmd_op2;
  logic       cmd_chain;
  logic       a_rsp_ready, b_rsp_ready;

  logic        a_cmd_ready, b_cmd_ready;
  logic [2:0]  a_alu_opcode, b_alu_opcode;
  logic [7:0]  a_alu_operand1, b_alu_operand1, a_alu_operand2, b_alu_operand2;
  logic [15:0] a_alu_result, b_alu_result;
  logic        a_alu_flagC, b_alu_flagC, a_alu_flagZ, b_alu_flagZ;
  logic        a_rsp_valid, b_rsp_valid;
  logic [15:0] a_rsp_result, b_rsp_result;
  logic        a_rsp_c, b_rsp_c, a_rsp_z, b_rsp_z;
  logic        a_busy, b_busy;
  logic [15:0] a_op_count;
  logic [3:0]  b_op_count;

  // Behavioural ALU; carry on logic/MUL ops is deliberately junk (1).
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic        c;
    c = 1'b1;
    case (op)
      3'b000:  begin r = {8'h00, a} + {8'h00, b}; c = r[8]; end
      3'b001:  begin r = {8'h00, a} - {8'h00, b}; c = (a < b); end
      3'b010:  r = {8'h00, a} * {8'h00, b};
      3'b011:  r = {8'h00, a & b};
      3'b100:  r = {8'h00, a | b};
      3'b101:  r = {8'h00, ~(a & b)};
      3'b110:  r = {8'h00, ~(a | b)};
      default: r = {8'h00, a ^ b};
    endcase
    return {c, (r == 16'h0000), r};
  endfunction

  assign {a_alu_flagC, a_alu_flagZ, a_alu_result} = alu_f(a_alu_opcode, a_alu_operand1, a_alu_operand2);
  assign {b_alu_flagC, b_alu_flagZ, b_alu_result} = alu_f(b_alu_opcode, b_alu_operand1, b_alu_operand2);

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .cmd_valid(cmd_valid && !sel), .cmd_ready(a_cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_chain(cmd_chain),
    .alu_opcode(a_alu_opcode), .alu_operand1(a_alu_operand1), .alu_operand2(a_alu_operand2),
    .alu_result(a_alu_result), .alu_flagC(a_alu_flagC), .alu_flagZ(a_alu_flagZ),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_result(a_rsp_result),
    .rsp_c(a_rsp_c), .rsp_z(a_rsp_z), .busy(a_busy), .op_count(a_op_count)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .cmd_valid(cmd_valid && sel), .cmd_ready(b_cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_chain(cmd_chain),
    .alu_opcode(b_alu_opcode), .alu_operand1(b_alu_operand1), .alu_operand2(b_alu_operand2),
    .alu_result(b_alu_result), .alu_flagC(b_alu_flagC), .alu_flagZ(b_alu_flagZ),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
    .rsp_c(b_rsp_c), .rsp_z(b_rsp_z), .busy(b_busy), .op_count(b_op_count)
  );

  logic        m_cmd_ready, m_rsp_valid, m_rsp_ready, m_rsp_c, m_rsp_z, m_busy;
  logic [15:0] m_rsp_result, m_op_count;
  logic [7:0]  m_alu_op1;
  logic [2:0]  m_alu_opcode;
  assign m_cmd_ready  = sel ? b_cmd_ready    : a_cmd_ready;
  assign m_rsp_valid  = sel ? b_rsp_valid    : a_rsp_valid;
  assign m_rsp_ready  = sel ? b_rsp_ready    : a_rsp_ready;
  assign m_rsp_result = sel ? b_rsp_result   : a_rsp_result;
  assign m_rsp_c      = sel ? b_rsp_c        : a_rsp_c;
  assign m_rsp_z      = sel ? b_rsp_z        : a_rsp_z;
  assign m_busy       = sel ? b_busy         : a_busy;
  assign m_op_count   = sel ? {12'h000, b_op_count} : a_op_count;
  assign m_alu_op1    = sel ? b_alu_operand1 : a_alu_operand1;
  assign m_alu_opcode = sel ? b_alu_opcode   : a_alu_opcode;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] o1, input logic [7:0] o2,
                       input logic ch, input logic [15:0] er, input logic ec, input logic ez);
    int n;
    cmd_opcode = op; cmd_op1 = o1; cmd_op2 = o2; cmd_chain = ch; cmd_valid = 1'b1;
    n = 0;
    while (!m_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 50), 32'd1);
    @(posedge clk);
    sb.push_back({er, ec, ez});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (!m_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, 32'(m_rsp_result), 32'(e.r));
      chk({tag, "_c"}, 32'(m_rsp_c), 32'(e.c));
      chk({tag, "_z"}, 32'(m_rsp_z), 32'(e.z));
    end
    if (m_rsp_ready) @(negedge clk);
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0; sel = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_op1 = 8'd0; cmd_op2 = 8'd0; cmd_chain = 1'b0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(a_cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_op_count", 32'(a_op_count), 32'd0);
    chk("rst_alu_op1", 32'(a_alu_operand1), 32'd0);
    chk("rst_rsp_result", 32'(a_rsp_result), 32'd0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);

    // Basic ops on the SETTLE_CYCLES=1 instance
    issue(3'b000, 8'hFF, 8'h01, 1'b0, 16'h0100, 1'b1, 1'b0);
    chk("add_busy", 32'(a_busy), 32'd1);
    chk("add_alu_op1", 32'(a_alu_operand1), 32'hFF);
    collect("add", 1);
    chk("add_op_count", 32'(a_op_count), 32'd1);
    issue(3'b001, 8'h03, 8'h05, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    collect("sub", 1);
    issue(3'b011, 8'hF0, 8'h0F, 1'b0, 16'h0000, 1'b0, 1'b1);
    collect("and", 1);

    // Chaining
    issue(3'b000, 8'h12, 8'h34, 1'b0, 16'h0046, 1'b0, 1'b0);
    collect("add2", 1);
    issue(3'b111, 8'hAA, 8'hFF, 1'b1, 16'h00B9, 1'b0, 1'b0);
    chk("chain_alu_op1", 32'(a_alu_operand1), 32'h46);
    collect("xor_chain", 1);
    issue(3'b010, 8'h10, 8'h10, 1'b0, 16'h0100, 1'b0, 1'b0);
    collect("mul", 1);
    chk("mul_op_count", 32'(a_op_count), 32'd6);

    // Backpressure with a competing command held valid
    a_rsp_ready = 1'b0;
    issue(3'b000, 8'h01, 8'h02, 1'b0, 16'h0003, 1'b0, 1'b0);
    collect("bp", 1);
    cmd_opcode = 3'b100; cmd_op1 = 8'h0C; cmd_op2 = 8'h30; cmd_chain = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(a_rsp_result), 32'h0003);
      chk("bp_cmd_ready", 32'(a_cmd_ready), 32'd0);
      chk("bp_busy", 32'(a_busy), 32'd1);
      chk("bp_op_count", 32'(a_op_count), 32'd6);
      chk("bp_alu_op1", 32'(a_alu_operand1), 32'h01);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_count", 32'(a_op_count), 32'd7);
    chk("bp_release_ready", 32'(a_cmd_ready), 32'd1);
    @(posedge clk);
    sb.push_back({16'h003C, 1'b0, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_busy", 32'(a_busy), 32'd1);
    chk("bp_next_opcode", 32'(a_alu_opcode), 32'd4);
    collect("bp_next", 1);
    chk("bp_next_count", 32'(a_op_count), 32'd8);

    // Reset mid-operation on the SETTLE_CYCLES=3 instance
    sel = 1'b1;
    issue(3'b000, 8'h20, 8'h22, 1'b0, 16'h0042, 1'b0, 1'b0);
    collect("b_add", 3);
    chk("b_add_count", 32'(b_op_count), 32'd1);
    issue(3'b110, 8'h00, 8'h00, 1'b0, 16'h00FF, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    b_rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(b_cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(b_busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("mid_rst_alu_opcode", 32'(b_alu_opcode), 32'd0);
    chk("mid_rst_alu_op1", 32'(b_alu_operand1), 32'd0);
    chk("mid_rst_alu_op2", 32'(b_alu_operand2), 32'd0);
    chk("mid_rst_rsp_result", 32'(b_rsp_result), 32'd0);
    chk("mid_rst_rsp_cz", 32'({b_rsp_c, b_rsp_z}), 32'd0);
    chk("mid_rst_op_count", 32'(b_op_count), 32'd0);
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) b_rst_n = 1'b1;
      chk("mid_rst_no_rsp", 32'(b_rsp_valid), 32'd0);
    end
    issue(3'b100, 8'h55, 8'h0F, 1'b1, 16'h000F, 1'b0, 1'b0);
    chk("post_rst_chain_op1", 32'(m_alu_op1), 32'h00);
    collect("post_rst", 3);
    chk("post_rst_count", 32'(m_op_count), 32'd1);

    // Counter wrap with CNT_W=4
    b_rst_n = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      issue(3'b100, 8'(i), 8'h00, 1'b0, 16'(i), 1'b0, (i == 0));
      collect("wrap_or", 3);
      if (i == 14) chk("wrap_count_15", 32'(b_op_count), 32'd15);
      if (i == 15) chk("wrap_count_0", 32'(b_op_count), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
